// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: late-queue entry layout and grant encoding.
package wb_arb_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } lq_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_LATE
    } wb_grant_t;

    function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        return XLEN'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the core (master) and the writeback port arbiter (slave).
interface wb_port_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
);
    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

    logic             pipe_valid_i;
    logic [REG_W-1:0] pipe_rd_i;
    logic [XLEN-1:0]  pipe_result_i;
    logic             late_valid_i;
    logic             late_ready_o;
    logic [REG_W-1:0] late_rd_i;
    logic [XLEN-1:0]  late_data_i;
    logic             rf_we_o;
    logic [REG_W-1:0] rf_rd_o;
    logic [XLEN-1:0]  rf_wdata_o;
    logic             stall_w_o;
    logic [XLEN-1:0]  pending_mask_o;
    logic [CNT_W-1:0] lq_count_o;

    modport master (
        output pipe_valid_i, pipe_rd_i, pipe_result_i,
        output late_valid_i, late_rd_i, late_data_i,
        input  late_ready_o, rf_we_o, rf_rd_o, rf_wdata_o,
        input  stall_w_o, pending_mask_o, lq_count_o
    );

    modport slave (
        input  pipe_valid_i, pipe_rd_i, pipe_result_i,
        input  late_valid_i, late_rd_i, late_data_i,
        output late_ready_o, rf_we_o, rf_rd_o, rf_wdata_o,
        output stall_w_o, pending_mask_o, lq_count_o
    );

endinterface

// File: rtl/wb_late_queue.sv
// Small FIFO of late-completion results; exposes per-slot valid and rd for hazard masking.
module wb_late_queue
    import wb_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  lq_entry_t                   push_entry,
    input  logic                        pop,
    output lq_entry_t                   head,
    output logic [CNT_W-1:0]            count,
    output logic [DEPTH-1:0]            slot_valid,
    output logic [DEPTH-1:0][REG_W-1:0] slot_rd
);

    lq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [DEPTH-1:0] valid_next;

    // Payload storage carries no reset; slot_valid alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_comb begin
        valid_next = slot_valid;
        if (pop) begin
            valid_next[rd_ptr] = 1'b0;
        end
        if (push) begin
            valid_next[wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            slot_valid <= valid_next;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_rd[i] = mem[i].rd;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && count == '0));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between in-order writeback and buffered late completions.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk_i,
    input logic              reset_i,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    lq_entry_t                      head;
    lq_entry_t                      push_entry;
    logic [CNT_W-1:0]               count;
    logic [LQ_DEPTH-1:0]            slot_valid;
    logic [LQ_DEPTH-1:0][REG_W-1:0] slot_rd;
    logic [SC_W-1:0]                starve_cnt;
    logic [XLEN-1:0]                pending_mask;
    logic                           pipe_req;
    logic                           q_nonempty;
    logic                           q_ready;
    logic                           push;
    logic                           pop;
    logic                           stall;
    wb_grant_t                      grant;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_W'(STARVE_LIMIT)) ? v : v + SC_W'(1);
    endfunction

    // Writes to x0 never need the port, so they are invisible to arbitration.
    assign pipe_req   = bus.pipe_valid_i && (bus.pipe_rd_i != '0);
    assign q_nonempty = (count != '0);
    assign q_ready    = (count < CNT_W'(LQ_DEPTH));
    assign push       = bus.late_valid_i && q_ready && !reset_i && (bus.late_rd_i != '0);
    assign pop        = (grant == GRANT_LATE) && !reset_i;
    assign push_entry = {bus.late_rd_i, bus.late_data_i};

    wb_late_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_queue (
        .clk        (clk_i),
        .rst        (reset_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd)
    );

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (slot_valid[i]) begin
                pending_mask = pending_mask | rd_onehot(slot_rd[i]);
            end
        end
        pending_mask[0] = 1'b0;
    end

    always_comb begin
        grant = GRANT_NONE;
        stall = 1'b0;
        if (pipe_req && pending_mask[bus.pipe_rd_i]) begin
            grant = GRANT_LATE;
            stall = 1'b1;
        end else if (q_nonempty && (starve_cnt == SC_W'(STARVE_LIMIT))) begin
            grant = GRANT_LATE;
            stall = pipe_req;
        end else if (pipe_req) begin
            grant = GRANT_PIPE;
        end else if (q_nonempty) begin
            grant = GRANT_LATE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (!q_nonempty || (grant == GRANT_LATE)) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_PIPE) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Combinational outputs are forced low for the whole time reset is held.
    always_comb begin
        bus.rf_we_o      = 1'b0;
        bus.rf_rd_o      = '0;
        bus.rf_wdata_o   = '0;
        bus.stall_w_o    = 1'b0;
        bus.late_ready_o = 1'b0;
        if (!reset_i) begin
            bus.late_ready_o = q_ready;
            bus.stall_w_o    = stall;
            case (grant)
                GRANT_LATE: begin
                    bus.rf_we_o    = 1'b1;
                    bus.rf_rd_o    = head.rd;
                    bus.rf_wdata_o = head.data;
                end
                GRANT_PIPE: begin
                    bus.rf_we_o    = 1'b1;
                    bus.rf_rd_o    = bus.pipe_rd_i;
                    bus.rf_wdata_o = bus.pipe_result_i;
                end
                default: begin
                    bus.rf_we_o = 1'b0;
                end
            endcase
        end
    end

    assign bus.pending_mask_o = pending_mask;
    assign bus.lq_count_o     = count;

endmodule
